// File: rtl/minisrc_ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcode values,
// sequencer state encoding, IR field positions and opcode classification.
package minisrc_ctrl_pkg;

  localparam int OPC_W       = 5;
  localparam int REG_FIELD_W = 4;

  // IR field positions (LSB of each field)
  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  // ALU-class opcodes
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3   = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_HALT   = 3'd3,
    CLS_OTHER  = 3'd4
  } op_class_e;

  // Groups an opcode by the execute sequence it needs
  function automatic op_class_e classifyOp(input logic [OPC_W-1:0] op);
    op_class_e cls;
    cls = CLS_OTHER;
    if ((op >= OP_ADD) && (op <= OP_OR)) begin
      cls = CLS_ALU3;
    end else if ((op == OP_MUL) || (op == OP_DIV)) begin
      cls = CLS_MULDIV;
    end else if ((op == OP_NEG) || (op == OP_NOT)) begin
      cls = CLS_UNARY;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register field into a one-hot register enable vector.
// With en_i low the whole vector is zero.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  parameter int FIELD_W  = 4
) (
  input  logic [FIELD_W-1:0]  field_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // One-hot decode, gated by the enable
  always_comb begin
    onehot_o = '0;
    if (en_i && (int'(field_i) < NUM_REGS)) begin
      onehot_o[field_i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control sequencer for the Mini-SRC datapath.
// Fetch in T0-T2 (T1 waits for mem_rdy), then T3-T6 register/ALU steps
// chosen by the opcode class. All strobes are Moore outputs of the state
// register combined with the current ir.
// Build option: define SEQ_HALT_EN to make opcode 11011 park the sequencer in
// HALT until reset; without it 11011 is treated as an illegal opcode.
module alu_control_sequencer
  import minisrc_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = OPC_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_rdy,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowin,
  output logic                Zhighin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPCODE_W-1:0] opcode,
  output logic [NUM_REGS-1:0] R0_15_in,
  output logic [NUM_REGS-1:0] R0_15_out,
  output logic                busy,
  output logic                illegal
);

`ifdef SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_e state_q, state_d;
  op_class_e opClass;

  logic [OPCODE_W-1:0]    irOpcode;
  logic [REG_FIELD_W-1:0] raField, rbField, rcField;
  logic [REG_FIELD_W-1:0] outField, inField;
  logic                   outEn, inEn;
  state_e                 endState;
  logic                   unusedIrBits;

  assign irOpcode     = ir[OPC_LSB +: OPCODE_W];
  assign raField      = ir[RA_LSB +: REG_FIELD_W];
  assign rbField      = ir[RB_LSB +: REG_FIELD_W];
  assign rcField      = ir[RC_LSB +: REG_FIELD_W];
  assign unusedIrBits = ^ir[RC_LSB-1:0];

  // After the final step of an instruction, run decides fetch-again or idle
  assign endState = run ? ST_T0 : ST_IDLE;

  // Classify the opcode; halt falls back to illegal when the option is off
  always_comb begin
    opClass = classifyOp(irOpcode);
    if ((opClass == CLS_HALT) && !HALT_EN) begin
      opClass = CLS_OTHER;
    end
  end

  // State register; clear drops straight back to IDLE, even mid-instruction
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing of fetch and execute steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_rdy) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (opClass)
          CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_d = ST_T4;
          CLS_HALT:                        state_d = ST_HALT;
          default:                         state_d = endState;
        endcase
      end
      ST_T4: begin
        if ((opClass == CLS_ALU3) || (opClass == CLS_MULDIV)) begin
          state_d = ST_T5;
        end else begin
          state_d = endState;
        end
      end
      ST_T5: begin
        if (opClass == CLS_MULDIV) begin
          state_d = ST_T6;
        end else begin
          state_d = endState;
        end
      end
      ST_T6:   state_d = endState;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control strobes and register-select requests for the current step
  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    opcode   = '0;
    illegal  = 1'b0;
    outEn    = 1'b0;
    outField = rbField;
    inEn     = 1'b0;
    inField  = raField;
    busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      ST_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (opClass)
          CLS_ALU3, CLS_MULDIV: begin
            outEn = 1'b1;
            Yin   = 1'b1;
          end
          CLS_UNARY: begin
            outEn  = 1'b1;
            opcode = irOpcode;
            Zlowin = 1'b1;
          end
          CLS_HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      ST_T4: begin
        case (opClass)
          CLS_ALU3: begin
            outEn    = 1'b1;
            outField = rcField;
            opcode   = irOpcode;
            Zlowin   = 1'b1;
          end
          CLS_MULDIV: begin
            outEn    = 1'b1;
            outField = rcField;
            opcode   = irOpcode;
            Zlowin   = 1'b1;
            Zhighin  = 1'b1;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1;
            inEn    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (opClass)
          CLS_ALU3: begin
            Zlowout = 1'b1;
            inEn    = 1'b1;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (opClass == CLS_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  reg_select_decoder #(
    .NUM_REGS (NUM_REGS),
    .FIELD_W  (REG_FIELD_W)
  ) uOutDecoder (
    .field_i  (outField),
    .en_i     (outEn),
    .onehot_o (R0_15_out)
  );

  reg_select_decoder #(
    .NUM_REGS (NUM_REGS),
    .FIELD_W  (REG_FIELD_W)
  ) uInDecoder (
    .field_i  (inField),
    .en_i     (inEn),
    .onehot_o (R0_15_in)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer. Each instruction is turned
// into the list of per-cycle strobe sets it should produce; the DUT is
// compared against that list every cycle on the falling clock edge.
// Honors SEQ_HALT_EN the same way the design does.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic        busy;
    logic        illegal;
    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [4:0]  opc;
    logic [15:0] rin;
    logic [15:0] rout;
  } obs_t;

  logic        clock;
  logic        clear;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  opcode;
  logic [15:0] R0_15_in;
  logic [15:0] R0_15_out;
  logic        busy;
  logic        illegal;

  int   checkCount = 0;
  int   errorCount = 0;
  obs_t expQ[$];

`ifdef SEQ_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  alu_control_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .run       (run),
    .mem_rdy   (mem_rdy),
    .ir        (ir),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .Read      (Read),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zlowin    (Zlowin),
    .Zhighin   (Zhighin),
    .Zlowout   (Zlowout),
    .Zhighout  (Zhighout),
    .HIin      (HIin),
    .LOin      (LOin),
    .opcode    (opcode),
    .R0_15_in  (R0_15_in),
    .R0_15_out (R0_15_out),
    .busy      (busy),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packs the DUT outputs in the same layout as the expected records
  function automatic obs_t sampleOutputs();
    obs_t o;
    o = '{busy: busy, illegal: illegal, PCout: PCout, PCin: PCin, IncPC: IncPC,
          MARin: MARin, Read: Read, MDRin: MDRin, MDRout: MDRout, IRin: IRin,
          Yin: Yin, Zlowin: Zlowin, Zhighin: Zhighin, Zlowout: Zlowout,
          Zhighout: Zhighout, HIin: HIin, LOin: LOin, opc: opcode,
          rin: R0_15_in, rout: R0_15_out};
    return o;
  endfunction

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input obs_t actual, input obs_t expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic obs_t busyStep();
    obs_t e;
    e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic bit opIsLegal(input logic [4:0] op);
    int v;
    v = int'(op);
    return (v >= 3 && v <= 11) || v == 15 || v == 16 || v == 17 || v == 18 ||
           (HALT_ON && v == 27);
  endfunction

  // Builds the expected per-cycle strobe list for one instruction
  task automatic buildTrace(input logic [31:0] instr, input int stalls);
    obs_t e;
    int op, ra, rb, rc;
    op = int'(instr[31:27]);
    ra = int'(instr[26:23]);
    rb = int'(instr[22:19]);
    rc = int'(instr[18:15]);
    expQ.delete();
    e = busyStep(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.PCin = 1;
    expQ.push_back(e);
    for (int i = 0; i <= stalls; i++) begin
      e = busyStep(); e.Read = 1; e.MDRin = 1;
      expQ.push_back(e);
    end
    e = busyStep(); e.MDRout = 1; e.IRin = 1;
    expQ.push_back(e);
    if (op >= 3 && op <= 11) begin
      e = busyStep(); e.rout = 16'(1 << rb); e.Yin = 1; expQ.push_back(e);
      e = busyStep(); e.rout = 16'(1 << rc); e.opc = 5'(op); e.Zlowin = 1; expQ.push_back(e);
      e = busyStep(); e.Zlowout = 1; e.rin = 16'(1 << ra); expQ.push_back(e);
    end else if (op == 15 || op == 16) begin
      e = busyStep(); e.rout = 16'(1 << rb); e.Yin = 1; expQ.push_back(e);
      e = busyStep(); e.rout = 16'(1 << rc); e.opc = 5'(op); e.Zlowin = 1; e.Zhighin = 1;
      expQ.push_back(e);
      e = busyStep(); e.Zlowout = 1; e.LOin = 1; expQ.push_back(e);
      e = busyStep(); e.Zhighout = 1; e.HIin = 1; expQ.push_back(e);
    end else if (op == 17 || op == 18) begin
      e = busyStep(); e.rout = 16'(1 << rb); e.opc = 5'(op); e.Zlowin = 1; expQ.push_back(e);
      e = busyStep(); e.Zlowout = 1; e.rin = 16'(1 << ra); expQ.push_back(e);
    end else if (HALT_ON && op == 27) begin
      e = busyStep(); expQ.push_back(e);
    end else begin
      e = busyStep(); e.illegal = 1; expQ.push_back(e);
    end
  endtask

  // Holds clear low, then releases it with run low and confirms IDLE
  task automatic applyReset();
    @(negedge clock);
    clear = 1'b0;
    run = 1'b0;
    mem_rdy = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset hold", sampleOutputs(), obs_t'(0));
    clear = 1'b1;
    @(negedge clock);
    checkOutput("idle after reset", sampleOutputs(), obs_t'(0));
  endtask

  // Runs one instruction starting from IDLE or from a previous final step.
  // Called at a falling edge; returns at the falling edge of the last check.
  // abortAt >= 0 pulls clear low right after that step has been checked.
  task automatic applyStimulus(input string name, input logic [31:0] instr, input int stalls,
                               input bit nextRun, input int abortAt);
    int t1Last;
    int last;
    buildTrace(instr, stalls);
    t1Last = 1 + stalls;
    last = expQ.size() - 1;
    run = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput($sformatf("%s step%0d", name, k), sampleOutputs(), expQ[k]);
      if (k == abortAt) begin
        clear = 1'b0;
        #1;
        checkOutput($sformatf("%s async clear", name), sampleOutputs(), obs_t'(0));
        @(negedge clock);
        checkOutput($sformatf("%s cleared idle", name), sampleOutputs(), obs_t'(0));
        run = 1'b1;
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput($sformatf("%s restart T0", name), sampleOutputs(), expQ[0]);
        applyReset();
        return;
      end
      if (k == 0) ir = instr;
      if (k >= 1 && k <= t1Last) mem_rdy = (k == t1Last);
      else mem_rdy = 1'($urandom_range(0, 1));
      run = (k == last) ? nextRun : 1'($urandom_range(0, 1));
    end
    if (!nextRun && !(HALT_ON && instr[31:27] == 5'b11011)) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput($sformatf("%s idle after", name), sampleOutputs(), obs_t'(0));
    end
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] instr;
    logic [4:0]  op;
    int          cls;
    instr = $urandom;
    cls = $urandom_range(0, 3);
    case (cls)
      0: op = 5'($urandom_range(3, 11));
      1: op = ($urandom_range(0, 1) == 1) ? 5'd15 : 5'd16;
      2: op = ($urandom_range(0, 1) == 1) ? 5'd17 : 5'd18;
      default: begin
        op = 5'($urandom_range(0, 31));
        for (int t = 0; t < 200 && opIsLegal(op); t++) op = 5'($urandom_range(0, 31));
        if (opIsLegal(op)) op = 5'd31;
      end
    endcase
    instr[31:27] = op;
    return instr;
  endfunction

  initial begin
    clear = 1'b0;
    run = 1'b0;
    mem_rdy = 1'b0;
    ir = 32'h0;
    #1;
    checkOutput("reset state", sampleOutputs(), obs_t'(0));
    applyReset();

    applyStimulus("rol", 32'h48918000, 0, 1'b0, -1);
    applyStimulus("add stall", 32'h18918000, 3, 1'b1, -1);
    applyStimulus("mul", 32'h78118000, 0, 1'b1, -1);
    applyStimulus("neg", 32'h8A280000, 1, 1'b0, -1);
    applyStimulus("illegal", 32'hF8000000, 0, 1'b1, -1);
    applyStimulus("div", 32'h80000000 | 32'h00398000, 2, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      applyStimulus($sformatf("rand%0d", n), randomInstr(), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), -1);
    end

    applyStimulus("abort", 32'h18918000, 0, 1'b1, 4);
    applyStimulus("after abort", 32'h90300000, 0, 1'b0, -1);

    applyStimulus("halt op", 32'hD8000000, 0, 1'b1, -1);
    if (HALT_ON) begin
      for (int h = 0; h < 4; h++) begin
        run = 1'b1;
        mem_rdy = 1'($urandom_range(0, 1));
        @(negedge clock);
        checkOutput($sformatf("halted%0d", h), sampleOutputs(), obs_t'(0));
      end
      applyReset();
      applyStimulus("after halt", 32'h18918000, 0, 1'b0, -1);
    end else begin
      applyStimulus("after halt op", 32'h50918000, 1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
